button_conditioner: RTL and testbench
=====================================

# button_conditioner

Converts a raw, asynchronous, bouncing push-button into clean single-cycle event pulses for downstream control FSMs. Its `o_press` and `o_click` outputs drive the `i_start`-style inputs of the lab controllers directly. The signal path is a 2-FF synchronizer, then a stability-counter debouncer, then a 3-state press-classification FSM (short click vs. long press).

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before the debounced level changes. Must be ≥1.
- `LONG_PRESS_CYCLES`, default 12500000: cycles the debounced level must stay high to count as a long press. Must be ≥1.
- `i_clk`  input  1  system clock.
- `i_reset`  input  1  reset, synchronous, active-high.
- `i_button`  input  1  raw button, active-high, asynchronous to `i_clk`.
- `o_level`  output  1  debounced button level.
- `o_press`  output  1  one-cycle pulse on each debounced rising edge.
- `o_release`  output  1  one-cycle pulse on each debounced falling edge.
- `o_click`  output  1  one-cycle pulse on a release that occurs before the long-press threshold.
- `o_long_press`  output  1  one-cycle pulse when the hold reaches `LONG_PRESS_CYCLES`.

## Operation
- **Synchronizer:** `r_sync1 <= i_button`, then `r_sync2 <= r_sync1`. Both reset to 0.
- **Debounce counter** (width `$clog2(DEBOUNCE_CYCLES+1)`):
  - If `r_sync2 == o_level`, the counter clears to 0.
  - Otherwise it increments.
  - On a mismatch edge where the counter equals `DEBOUNCE_CYCLES-1`, `o_level` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `o_level`.
- **Classification FSM.** States are `S_UP`, `S_DOWN` and `S_HELD`. Default encoding is 2 bits. Undefined codes go to `S_UP`.
  - **`S_UP`:** on a debounced rise, go to `S_DOWN`, pulse `o_press`, and clear the hold counter.
  - **`S_DOWN`:** the hold counter increments every cycle.
    - A debounced fall goes to `S_UP` and pulses both `o_release` and `o_click`.
    - Otherwise, when the hold count reaches `LONG_PRESS_CYCLES`, go to `S_HELD` and pulse `o_long_press`.
  - **`S_HELD`:** on a debounced fall, go to `S_UP` and pulse `o_release` only (no `o_click`).
- **Hold counter:** width `$clog2(LONG_PRESS_CYCLES+1)`. It does not count in `S_UP` or `S_HELD`, so it never wraps.
- **Registered outputs:** all pulse outputs are registered and are exactly one cycle wide.
- **Mutual exclusion:** `o_press` and `o_release` are never high together. Because the debouncer changes level at most once per `DEBOUNCE_CYCLES`, at most one edge event occurs per cycle.
- **Fall and threshold in the same cycle:** if the debounced fall coincides with the cycle in which the threshold would be reached, the fall wins. The result is `o_release` plus `o_click`, and no `o_long_press`.

## Timing
- **Reset values:** after any reset edge, all outputs, both counters, and both sync FFs are 0, and the state is `S_UP`.
- **Reset mid-operation:** reset aborts the operation immediately and emits no pulse. If the button is still held after reset, it is treated as a new press (full synchronizer + debounce latency).
- **Press latency:** say `i_button` is stable high from before clock edge k.
  - `r_sync2` is high after edge k+1.
  - `o_level` and `o_press` go high together after edge k+1+`DEBOUNCE_CYCLES`.
  - Total: `DEBOUNCE_CYCLES`+2 edges.
- **Release latency:** symmetric with press. `o_release` (and `o_click` if applicable) asserts in the first cycle `o_level` is low.
- **Long-press timing:** take the first cycle with `o_level`=1 as cycle 0. `o_long_press` is high in cycle `LONG_PRESS_CYCLES`, provided `o_level` remains 1 through that cycle.
- **Throughput:** there is no handshake. Pulses are fire-and-forget, and the consumer must sample every cycle.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=10 in simulation.
- **Reset:** assert reset with `i_button`=1 → all outputs 0 during reset. After release of reset, `o_press` fires 6 cycles later.
- **Bounce rejection:** toggle `i_button` high 3 cycles, low 1, high 2, low 1, high steady → exactly one `o_press`. It fires 6 cycles after the final steady rise, and no `o_release` occurs.
- **Short click:** hold 8 cycles past `o_press`, then release → `o_release` and `o_click` in the same cycle, 6 cycles after the raw fall, and no `o_long_press`.
- **Long press:** hold steady → `o_long_press` exactly 10 cycles after `o_press`. On release, `o_release` fires with `o_click`=0.
- **Boundary:** time the raw fall so the debounced fall lands in cycle 10 after `o_press` → `o_click` fires and `o_long_press` never fires. Repeat with the debounced fall in cycle 11 → `o_long_press` in cycle 10, then `o_release` only.
- **Mid-hold reset:** assert reset in cycle 5 of a hold → outputs 0 and no pulses during reset. A still-held button re-presses after 6 cycles.

Source files
------------

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Function : Synchronise, debounce and classify a raw push-button into
//            press / release / click / long-press single-cycle pulses.
// Revision : 1.0
// ============================================================================
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 12500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long_press
);

    localparam int unsigned c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned c_HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] S_UP   = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;

    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   db_cnt_q;
    logic [c_DB_W-1:0]   db_cnt_d;
    logic                level_q;
    logic                level_d;
    logic                w_toggle;
    logic                w_rise;
    logic                w_fall;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [c_HOLD_W-1:0] hold_cnt_q;
    logic [c_HOLD_W-1:0] hold_cnt_d;
    logic                press_q;
    logic                press_d;
    logic                release_q;
    logic                release_d;
    logic                click_q;
    logic                click_d;
    logic                long_q;
    logic                long_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    // Any agreement with the current level restarts the stability count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        w_toggle = 1'b0;
        if (r_sync2 == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == c_DB_LAST) begin
            w_toggle = 1'b1;
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign w_rise = w_toggle & ~level_q;
    assign w_fall = w_toggle &  level_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_UP;
        end else begin
            state_q <= state_d;
        end
    end

    // A fall takes priority over reaching the long-press threshold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UP: begin
                if (w_rise) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (w_fall) begin
                    state_d = S_UP;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                if (w_fall) begin
                    state_d = S_UP;
                end
            end
            default: begin
                state_d = S_UP;
            end
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        click_d    = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            S_UP: begin
                if (w_rise) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            S_DOWN: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (w_fall) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    long_d = 1'b1;
                end
            end
            S_HELD: begin
                if (w_fall) begin
                    release_d = 1'b1;
                end
            end
            default: begin
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            long_q     <= long_d;
        end
    end

    assign o_level      = level_q;
    assign o_press      = press_q;
    assign o_release    = release_q;
    assign o_click      = click_q;
    assign o_long_press = long_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Function : Self-checking bench: directed scenarios plus randomized button
//            activity compared cycle by cycle against a history-based model.
// Revision : 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int LP  = 10;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_button;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_click;
    logic o_long_press;

    always #5 i_clk = ~i_clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_button    (i_button),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_click     (o_click),
        .o_long_press(o_long_press)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: raw samples since the last reset, edge count, press edge.
    int raw_q[$];
    int m_n  = 0;
    int m_p  = 0;
    bit m_level = 1'b0;
    bit m_long_fired = 1'b0;

    int n_press, n_rel, n_click, n_long;
    int t_press, t_rel, t_click, t_long;

    typedef struct {
        int hold;
        int n_press;
        int press_off;
        int rel_off;
        int n_click;
        int n_long;
        int long_off;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        n_press = 0; n_rel = 0; n_click = 0; n_long = 0;
        t_press = -1; t_rel = -1; t_click = -1; t_long = -1;
    endtask

    function automatic int outs();
        return int'({o_level, o_press, o_release, o_click, o_long_press});
    endfunction

    // One clock: capture inputs, advance, sample #1 later, compare with model.
    task automatic tick();
        bit         b;
        bit         r;
        bit         tog;
        bit         rise;
        bit         fall;
        bit         lng;
        int         ds;
        logic [4:0] exp_v;
        b = i_button;
        r = i_reset;
        @(posedge i_clk);
        #1;
        cyc++;
        exp_v = '0;
        if (r) begin
            raw_q.delete();
            m_n = 0;
            m_p = 0;
            m_level = 1'b0;
            m_long_fired = 1'b0;
        end else begin
            raw_q.push_back(int'(b));
            // Level flips once the last DEB synchronised samples all disagree.
            tog = 1'b1;
            for (int j = m_n - DEB + 1; j <= m_n; j++) begin
                if (j < 0) begin
                    tog = 1'b0;
                end else begin
                    ds = (j >= 2) ? raw_q[j-2] : 0;
                    if (ds == int'(m_level)) tog = 1'b0;
                end
            end
            rise = tog && !m_level;
            fall = tog && m_level;
            lng  = m_level && !fall && !m_long_fired && (m_n - m_p == LP);
            exp_v = {m_level ^ tog, rise, fall, fall && !m_long_fired, lng};
            if (rise) begin
                m_p = m_n;
                m_long_fired = 1'b0;
            end
            if (lng) m_long_fired = 1'b1;
            m_level = m_level ^ tog;
            m_n++;
        end
        check("model_outputs", outs(), int'(exp_v));
        if (o_press)      begin n_press++; t_press = cyc; end
        if (o_release)    begin n_rel++;   t_rel   = cyc; end
        if (o_click)      begin n_click++; t_click = cyc; end
        if (o_long_press) begin n_long++;  t_long  = cyc; end
    endtask

    initial begin
        vec_t tbl[6];
        int   t0;
        int   len;
        int   bounce[7];

        tbl[0] = '{3,  0, -1, -1, 0, 0, -1};
        tbl[1] = '{4,  1,  6, 10, 1, 0, -1};
        tbl[2] = '{8,  1,  6, 14, 1, 0, -1};
        tbl[3] = '{10, 1,  6, 16, 1, 0, -1};
        tbl[4] = '{11, 1,  6, 17, 0, 1, 16};
        tbl[5] = '{15, 1,  6, 21, 0, 1, 16};
        bounce = '{1, 1, 1, 0, 1, 1, 0};

        clear_log();
        i_reset  = 1'b1;
        i_button = 1'b0;
        repeat (3) tick();
        check("reset_state", outs(), 0);
        i_reset = 1'b0;
        repeat (5) tick();

        // Reset with the button held: quiet during reset, press 6 cycles after.
        i_reset  = 1'b1;
        i_button = 1'b1;
        repeat (3) begin
            tick();
            check("reset_held_outputs", outs(), 0);
        end
        i_reset = 1'b0;
        clear_log();
        t0 = cyc;
        repeat (10) tick();
        check("reset_press_count", n_press, 1);
        check("reset_press_latency", t_press - t0, 6);
        i_button = 1'b0;
        repeat (40) tick();

        // Bounce rejection.
        clear_log();
        t0 = cyc;
        foreach (bounce[i]) begin
            i_button = bounce[i][0];
            tick();
        end
        i_button = 1'b1;
        repeat (20) tick();
        check("bounce_press_count", n_press, 1);
        check("bounce_press_latency", t_press - t0, 13);
        check("bounce_release_count", n_rel, 0);
        i_button = 1'b0;
        repeat (40) tick();

        // Hold-duration table: short clicks, boundary and long presses.
        for (int k = 0; k < 6; k++) begin
            clear_log();
            t0 = cyc;
            i_button = 1'b1;
            repeat (tbl[k].hold) tick();
            i_button = 1'b0;
            repeat (40) tick();
            check($sformatf("tbl%0d_press_count", k), n_press, tbl[k].n_press);
            check($sformatf("tbl%0d_press_off", k), (n_press > 0) ? t_press - t0 : -1, tbl[k].press_off);
            check($sformatf("tbl%0d_release_count", k), n_rel, tbl[k].n_press);
            check($sformatf("tbl%0d_release_off", k), (n_rel > 0) ? t_rel - t0 : -1, tbl[k].rel_off);
            check($sformatf("tbl%0d_click_count", k), n_click, tbl[k].n_click);
            check($sformatf("tbl%0d_click_off", k), (n_click > 0) ? t_click - t0 : -1,
                  (tbl[k].n_click > 0) ? tbl[k].rel_off : -1);
            check($sformatf("tbl%0d_long_count", k), n_long, tbl[k].n_long);
            check($sformatf("tbl%0d_long_off", k), (n_long > 0) ? t_long - t0 : -1, tbl[k].long_off);
        end

        // Reset in cycle 5 of a hold, button kept down afterwards.
        clear_log();
        i_button = 1'b1;
        repeat (11) tick();
        i_reset = 1'b1;
        repeat (3) begin
            tick();
            check("midhold_reset_outputs", outs(), 0);
        end
        check("midhold_press_before", n_press, 1);
        check("midhold_no_release", n_rel, 0);
        check("midhold_no_long", n_long, 0);
        i_reset = 1'b0;
        clear_log();
        t0 = cyc;
        repeat (8) tick();
        check("midhold_repress_count", n_press, 1);
        check("midhold_repress_latency", t_press - t0, 6);
        i_button = 1'b0;
        repeat (40) tick();

        // Randomized activity with occasional resets.
        repeat (200) begin
            if ($urandom_range(0, 29) == 0) begin
                i_reset = 1'b1;
                len = $urandom_range(1, 3);
            end else begin
                i_reset  = 1'b0;
                i_button = ~i_button;
                len = $urandom_range(1, 25);
            end
            repeat (len) tick();
            i_reset = 1'b0;
        end
        i_button = 1'b0;
        repeat (40) tick();
        check("final_level_low", int'(o_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
